// File: rtl/hbm_wt_scale_reader.sv
// Walks one CHin row of HBM weight beats. Each group is one FP16 scale beat
// followed by its INT4 weight beats. Every weight is re-emitted with its scale and block index.
module hbm_wt_scale_reader #(
  parameter int HBM_AXI_DATA_WIDTH = 256,
  parameter int WT_DW              = 4,
  parameter int WT_quant_scale_DW  = 16,
  parameter int T_quant_block      = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [15:0]                   ch_in,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [HBM_AXI_DATA_WIDTH-1:0] s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [HBM_AXI_DATA_WIDTH-1:0] m_wt,
  output logic [WT_quant_scale_DW-1:0]  m_scale,
  output logic [15:0]                   m_block,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    dbg_state
);

  localparam int WT_CH_Tgroup = T_quant_block * HBM_AXI_DATA_WIDTH / WT_quant_scale_DW;
  localparam int WT_PER_BEAT  = HBM_AXI_DATA_WIDTH / WT_DW;
  localparam int GROUP_BEATS  = WT_CH_Tgroup / WT_PER_BEAT;
  localparam int BLK_SHIFT    = $clog2(T_quant_block / WT_PER_BEAT);
  localparam int LSB_W        = $clog2(WT_PER_BEAT);
  localparam int N_SLOT       = HBM_AXI_DATA_WIDTH / WT_quant_scale_DW;
  localparam int SLOT_W       = $clog2(N_SLOT);

  typedef enum logic [1:0] {IDLE, SCALE, WT, FIN} state_t;

  state_t                                   state;
  logic [15:0]                              total;
  logic [15:0]                              global_beat;
  logic [15:0]                              beat_cnt;
  logic [N_SLOT-1:0][WT_quant_scale_DW-1:0] scale_reg;

  logic              accept;
  logic              beat_last;
  logic              grp_last;
  logic              ch_ok;
  logic [15:0]       slot_full;
  logic [SLOT_W-1:0] slot;

  // Handshake: a beat transfers on a cycle where valid && ready at the rising edge.
  // The source must hold s_valid/s_data until accepted; m_* are held while m_valid && !m_ready.
  assign s_ready   = (state == SCALE) || ((state == WT) && (!m_valid || m_ready));
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign accept    = s_valid && s_ready;
  assign beat_last = (global_beat == total - 16'd1);
  assign grp_last  = beat_last || (beat_cnt == 16'(GROUP_BEATS - 1));
  assign ch_ok     = (ch_in != 16'd0) && (ch_in[LSB_W-1:0] == '0);
  assign slot_full = beat_cnt >> BLK_SHIFT;
  assign slot      = slot_full[SLOT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      total       <= '0;
      global_beat <= '0;
      beat_cnt    <= '0;
      scale_reg   <= '0;
      m_valid     <= 1'b0;
      m_wt        <= '0;
      m_scale     <= '0;
      m_block     <= '0;
      m_last      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Output register drains on m_ready; a load in WT below takes precedence.
      if (m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ch_ok) begin
              total       <= ch_in >> LSB_W;
              global_beat <= '0;
              state       <= SCALE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SCALE: begin
          if (s_valid) begin
            scale_reg <= s_data;
            beat_cnt  <= '0;
            state     <= WT;
          end
        end
        WT: begin
          if (accept) begin
            m_valid     <= 1'b1;
            m_wt        <= s_data;
            m_scale     <= scale_reg[slot];
            m_block     <= global_beat >> BLK_SHIFT;
            m_last      <= beat_last;
            global_beat <= global_beat + 16'd1;
            beat_cnt    <= beat_cnt + 16'd1;
            if (grp_last) state <= beat_last ? FIN : SCALE;
          end
        end
        FIN: begin
          if (!m_valid || m_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbm_wt_scale_reader.sv
// Bench for hbm_wt_scale_reader: random row contents and backpressure. Expected beats
// come from a group/slot model of the row layout, and a monitor pops and compares them.
module tb_hbm_wt_scale_reader;
  localparam int W  = 256;
  localparam int EW = W + 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   ch_in = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_wt;
  logic [15:0]   m_scale;
  logic [15:0]   m_block;
  logic          m_last;
  logic          busy, done, err;
  logic [1:0]    dbg_state;

  hbm_wt_scale_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_in(ch_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_wt(m_wt), .m_scale(m_scale),
    .m_block(m_block), .m_last(m_last), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  src_q[$];
  bit  bp = 1'b0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_acc_cyc = 0;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: row = groups of (1 scale beat, up to 32 weight beats).
  task automatic build_row(input int ch);
    int total, g, n, b, gb;
    logic [W-1:0] sb, wb;
    logic [15:0] sc;
    total = ch / 64;
    g = 0;
    while (g * 32 < total) begin
      n = (total - g * 32 > 32) ? 32 : total - g * 32;
      sb = rand_beat();
      src_q.push_back(sb);
      for (b = 0; b < n; b++) begin
        gb = g * 32 + b;
        wb = rand_beat();
        src_q.push_back(wb);
        sc = sb[16 * (b / 2) +: 16];
        exp_q.push_back({(gb == total - 1), 16'(gb / 2), sc, wb});
      end
      g++;
    end
  endtask

  // m_ready driver
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor / scoreboard
  logic          held = 1'b0;
  logic [EW-1:0] held_val;
  initial forever begin
    logic [EW-1:0] cur;
    @(negedge clk);
    cur = {m_last, m_block, m_scale, m_wt};
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (held) check("hold_stable", {m_valid, cur}, {1'b1, held_val});
      if (m_valid && !m_ready) begin
        check("s_ready_bp", s_ready, 1'b0);
        held = 1'b1;
        held_val = cur;
      end else begin
        held = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %h expected none", cur);
        end else begin
          check("beat", cur, exp_q.pop_front());
        end
      end
    end
  end

  // source driver: offers src_q[0..stop-1], holding each beat until accepted
  task automatic drive_src(input int stop);
    int idx = 0;
    bit acc = 1'b0;
    int guard = 0;
    while (idx < stop && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin idx++; s_valid = 1'b0; acc = 1'b0; end
      if (idx < stop && !s_valid && (bp ? $urandom_range(0, 3) != 0 : 1'b1)) begin
        s_valid = 1'b1;
        s_data = src_q[idx];
      end
      if (idx < stop) begin
        @(negedge clk);
        acc = s_valid && s_ready;
        if (acc) last_acc_cyc = cyc;
      end
    end
    if (idx < stop) check("src_timeout", idx, stop);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] ch);
    @(posedge clk);
    #1;
    start = 1'b1;
    ch_in = ch;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_row(input int ch, input bit bpv);
    int d0, t;
    bp = bpv;
    src_q.delete();
    build_row(ch);
    d0 = done_cnt;
    pulse_start(16'(ch));
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    drive_src(src_q.size());
    t = 0;
    while (done_cnt == d0 && t < 500) begin @(negedge clk); t++; end
    @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("row_drained", exp_q.size(), 0);
    check("idle_after_done", busy, 1'b0);
    if (!bpv) check("done_latency", done_cyc - last_acc_cyc, 2);
    exp_q.delete();
  endtask

  task automatic err_case(input logic [15:0] ch);
    pulse_start(ch);
    @(negedge clk);
    check("err_pulse", {err, busy, s_ready}, 3'b100);
    @(negedge clk);
    check("err_clear", {err, busy, s_ready}, 3'b000);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {m_valid, m_last, s_ready, busy, done, err, m_wt, m_scale, m_block}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_row(2048, 1'b0);
    run_row(2176, 1'b0);
    run_row(2176, 1'b1);
    err_case(16'd0);
    err_case(16'd100);
    for (int i = 0; i < 4; i++) run_row(64 * $urandom_range(1, 80), 1'($urandom_range(0, 1)));

    // reset in the middle of a 2048 row, after 10 weight beats
    bp = 1'b0;
    src_q.delete();
    build_row(2048);
    d0 = done_cnt;
    pulse_start(16'd2048);
    drive_src(11);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrow_reset", {m_valid, m_last, s_ready, busy, done, err, m_wt, m_scale, m_block}, '0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);
    run_row(64, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t expected finish", $time);
    $fatal(1);
  end
endmodule

// File: doc/hbm_wt_scale_reader.md
HBM_WT_SCALE_READER -- requirements
Module: hbm_wt_scale_reader

Interface
REQ-001 The module SHALL have a parameter HBM_AXI_DATA_WIDTH, default 256, giving the HBM read beat width in bits.
REQ-002 The module SHALL have a parameter WT_DW, default 4, giving the INT4 weight width.
REQ-003 The module SHALL have a parameter WT_quant_scale_DW, default 16, giving the FP16 scale width.
REQ-004 The module SHALL have a parameter T_quant_block, default 128, giving the channels per quant block; WT_CH_Tgroup = T_quant_block*HBM_AXI_DATA_WIDTH/WT_quant_scale_DW (2048).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port start, input, 1 bit: one-cycle pulse that begins a CHin row read.
REQ-008 The module SHALL have port ch_in, input, 16 bits: CHin of the row, already padded to Tin; sampled on start.
REQ-009 The module SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, HBM_AXI_DATA_WIDTH): the HBM read beat stream.
REQ-010 The module SHALL have ports m_valid (output, 1) and m_ready (input, 1): the handshake for weight beats.
REQ-011 The module SHALL have ports m_wt (output, HBM_AXI_DATA_WIDTH), m_scale (output, 16) and m_block (output, 16): 64 weights, their FP16 scale, and the global quant block index.
REQ-012 The module SHALL have port m_last, output, 1: marks the final weight beat of the row.
REQ-013 The module SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and err (output, 1, one-cycle pulse).

Function
REQ-014 The row layout SHALL be a repetition of groups, each consisting of 1 scale beat (16 scales, scale k in bits [16k+15:16k]) followed by the group's weight beats.
REQ-015 Every group except the last SHALL carry 2048 channels, i.e. 32 weight beats.
REQ-016 The last group SHALL carry ch_in - 2048*(number of full groups) channels, i.e. that count divided by 64 weight beats; it SHALL NOT be empty.
REQ-017 The FSM SHALL have states IDLE, SCALE, WT and FIN; reset SHALL put it in IDLE.
REQ-018 In IDLE, start with ch_in nonzero and ch_in mod 64 == 0 SHALL latch the row beat count ch_in/64 and move to SCALE.
REQ-019 In IDLE, start with any other ch_in value SHALL pulse err for 1 cycle and stay in IDLE.
REQ-020 In SCALE, s_ready SHALL be 1; an accepted beat SHALL be captured into a 256-bit scale register, the beat counter SHALL clear to 0, and the FSM SHALL move to WT.
REQ-021 In WT, s_ready SHALL equal (!m_valid || m_ready), giving a single output register with no data loss.
REQ-022 An accepted WT beat SHALL load m_wt=s_data, m_scale=scale_reg[16*(beat_cnt>>1) +: 16], m_block=global_beat>>1, and m_last=(global_beat==total-1), and SHALL set m_valid.
REQ-023 After the last beat of a group: if it was the row's last beat the FSM SHALL go to FIN, otherwise to SCALE.
REQ-024 In FIN, the FSM SHALL wait until the output register drains (m_valid==0 or m_ready), then pulse done for 1 cycle and return to IDLE.
REQ-025 m_valid SHALL clear on m_ready unless a new beat is loaded in the same cycle.
REQ-026 Output data SHALL be held stable while m_valid && !m_ready.
REQ-027 In IDLE and FIN, s_ready SHALL be 0.
REQ-028 busy SHALL be 1 in SCALE, WT and FIN.
REQ-029 start while busy SHALL be ignored.
REQ-030 Beat latency from s_valid&&s_ready to m_valid SHALL be 1 cycle; throughput SHALL be 1 beat per cycle under no backpressure, plus 1 cycle per scale beat.
REQ-031 The counters SHALL be 16 bits wide; no wrap-around is possible for ch_in up to 65472.

Reset
REQ-032 While rst_n==0 at a clk edge, the block SHALL clear the FSM to IDLE, zero all counters and the scale register, and drive m_valid, m_last, s_ready, busy, done and err to 0, and m_wt, m_scale and m_block to 0.
REQ-033 Reset asserted mid-row SHALL abandon the row with no done pulse; the first cycle after release SHALL accept a new start.

Verification
REQ-034 ch_in=2048, no backpressure -> 1 scale beat + 32 weight beats, m_block 0..15, m_scale changes every 2 beats, m_last on beat 31, done 2 cycles after the last accept.
REQ-035 ch_in=2176 -> group 0 with 32 beats, then scale beat, then 2 beats with m_block 16 and m_scale = scale slot 0 of the second scale beat; m_last on the 34th weight beat.
REQ-036 ch_in=2176 with m_ready randomly 50% -> output sequence identical to the no-backpressure run, no dropped or duplicated beats, s_ready 0 whenever m_valid && !m_ready.
REQ-037 ch_in=0 or ch_in=100 -> err pulses 1 cycle, busy stays 0, s_ready stays 0.
REQ-038 rst_n low for 1 cycle at weight beat 10 of ch_in=2048 -> all outputs 0 next cycle, no done; a new start with ch_in=64 -> 1 scale beat + 1 weight beat with m_last=1, then done.
